// File: rtl/ysyx_22040931_divider_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
// The master drives operands and control; the slave returns readiness, status and the result.
interface ysyx_22040931_divider_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] num1;
    logic [63:0] num2;
    logic        is_signed;
    logic        is_word;
    logic        is_rem;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    modport master (
        output flush, in_valid, num1, num2, is_signed, is_word, is_rem, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, num1, num2, is_signed, is_word, is_rem, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22040931_divider.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Define YSYX_22040931_DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow right at accept.
module ysyx_22040931_divider (
    input logic                      clk,
    input logic                      rst_n,
    ysyx_22040931_divider_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] dvsr_q, dvsr_d;
    logic [63:0] dvnd_q, dvnd_d;
    logic [63:0] result_q, result_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        word_q, word_d;
    logic        sel_rem_q, sel_rem_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    logic [63:0] a_ext, b_ext, a_abs, b_abs;
    logic        a_neg, b_neg, acc_dz, acc_ovf;
    logic [64:0] shifted, diff;
    logic        ge;
    logic [63:0] step_rem, step_quo, fix_quo, fix_rem;

    function automatic logic [63:0] fmt(input logic word, input logic [63:0] v);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // RISC-V defined results for divide-by-zero and most-negative / -1
    function automatic logic [63:0] special_val(input logic sel_rem, input logic ovf,
                                                input logic [63:0] dvnd);
        if (sel_rem)
            return ovf ? 64'd0 : dvnd;
        return ovf ? dvnd : '1;
    endfunction

    always_comb begin
        a_ext   = bus.is_word ? (bus.is_signed ? {{32{bus.num1[31]}}, bus.num1[31:0]}
                                               : {32'd0, bus.num1[31:0]}) : bus.num1;
        b_ext   = bus.is_word ? (bus.is_signed ? {{32{bus.num2[31]}}, bus.num2[31:0]}
                                               : {32'd0, bus.num2[31:0]}) : bus.num2;
        a_neg   = bus.is_signed & a_ext[63];
        b_neg   = bus.is_signed & b_ext[63];
        a_abs   = a_neg ? 64'd0 - a_ext : a_ext;
        b_abs   = b_neg ? 64'd0 - b_ext : b_ext;
        acc_dz  = (b_ext == 64'd0);
        acc_ovf = bus.is_signed && (b_ext == '1) &&
                  (a_ext == (bus.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    end

    // One restoring step; the shifted partial remainder needs a 65th bit for 64-bit divisors
    always_comb begin
        shifted  = {rem_q, quo_q[63]};
        diff     = shifted - {1'b0, dvsr_q};
        ge       = ~diff[64];
        step_rem = ge ? diff[63:0] : shifted[63:0];
        step_quo = {quo_q[62:0], ge};
        fix_quo  = neg_quo_q ? 64'd0 - step_quo : step_quo;
        fix_rem  = neg_rem_q ? 64'd0 - step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        dvnd_d    = dvnd_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        word_d    = word_q;
        sel_rem_d = sel_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    rem_d     = 64'd0;
                    quo_d     = bus.is_word ? {a_abs[31:0], 32'd0} : a_abs;
                    dvsr_d    = b_abs;
                    dvnd_d    = a_ext;
                    cnt_d     = bus.is_word ? 7'd32 : 7'd64;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    word_d    = bus.is_word;
                    sel_rem_d = bus.is_rem;
                    dz_d      = acc_dz;
                    ovf_d     = acc_ovf;
                    state_d   = CALC;
`ifdef YSYX_22040931_DIV_EARLY_OUT_EN
                    if (acc_dz || acc_ovf) begin
                        result_d = fmt(bus.is_word, special_val(bus.is_rem, acc_ovf, a_ext));
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = DONE;
                    if (dz_q || ovf_q)
                        result_d = fmt(word_q, special_val(sel_rem_q, ovf_q, dvnd_q));
                    else
                        result_d = fmt(word_q, sel_rem_q ? fix_rem : fix_quo);
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= 64'd0;
            quo_q     <= 64'd0;
            dvsr_q    <= 64'd0;
            dvnd_q    <= 64'd0;
            result_q  <= 64'd0;
            cnt_q     <= 7'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            word_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            dvnd_q    <= dvnd_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            word_q    <= word_d;
            sel_rem_q <= sel_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_ysyx_22040931_divider.sv
// Directed self-checking bench for ysyx_22040931_divider; honours YSYX_22040931_DIV_EARLY_OUT_EN
// for the expected latency of divide-by-zero and overflow cases.
module tb_ysyx_22040931_divider;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22040931_divider_if bus();

    ysyx_22040931_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

`ifdef YSYX_22040931_DIV_EARLY_OUT_EN
    localparam int SPEC_D = 1;
    localparam int SPEC_W = 1;
`else
    localparam int SPEC_D = 65;
    localparam int SPEC_W = 33;
`endif
    localparam int LAT_D = 65;
    localparam int LAT_W = 33;

    typedef struct {
        string       name;
        logic        s;
        logic        w;
        logic        r;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    // Drive one operation, then count cycles from the accept edge until out_valid
    task automatic applyStimulus(input logic s, input logic w, input logic r,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output int lat);
        bus.is_signed = s;
        bus.is_word   = w;
        bus.is_rem    = r;
        bus.num1      = a;
        bus.num2      = b;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.num1      = 64'hA5A5_A5A5_A5A5_A5A5;
        bus.num2      = 64'h5A5A_5A5A_5A5A_5A5A;
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        if (bus.out_valid && bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vectors(input vec_t v[]);
        logic [63:0] res;
        int          lat;
        foreach (v[i]) begin
            applyStimulus(v[i].s, v[i].w, v[i].r, v[i].a, v[i].b, res, lat);
            tests++;
            if (res !== v[i].exp) begin
                fails++;
                $display("[TB] FAIL %s result: got %h expected %h", v[i].name, res, v[i].exp);
            end
            tests++;
            if (lat !== v[i].lat) begin
                fails++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.num1      = 64'd0;
        bus.num2      = 64'd0;
        bus.is_signed = 1'b0;
        bus.is_word   = 1'b0;
        bus.is_rem    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.result} !== 67'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got rdy=%b busy=%b ov=%b res=%h expected all zero",
                     bus.in_ready, bus.busy, bus.out_valid, bus.result);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_doubleword();
        vec_t v[] = '{
            '{"div_20_m3",   1'b1, 1'b0, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, LAT_D},
            '{"rem_20_m3",   1'b1, 1'b0, 1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, LAT_D},
            '{"divu_max_3",  1'b0, 1'b0, 1'b0, '1, 64'd3, 64'h5555_5555_5555_5555, LAT_D},
            '{"remu_max_big",1'b0, 1'b0, 1'b1, '1, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, LAT_D}
        };
        run_vectors(v);
    endtask

    task automatic test_div_zero();
        vec_t v[] = '{
            '{"divu_by_zero", 1'b0, 1'b0, 1'b0, 64'h1234, 64'd0, '1, SPEC_D},
            '{"remu_by_zero", 1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, 64'h1234, SPEC_D},
            '{"div_m5_zero",  1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, '1, SPEC_D},
            '{"rem_m5_zero",  1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, SPEC_D},
            '{"remw_zero",    1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, SPEC_W}
        };
        run_vectors(v);
    endtask

    task automatic test_overflow();
        vec_t v[] = '{
            '{"div_ovf",  1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, SPEC_D},
            '{"rem_ovf",  1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1, 64'd0, SPEC_D},
            '{"divw_ovf", 1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, SPEC_W},
            '{"remw_ovf", 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, SPEC_W}
        };
        run_vectors(v);
    endtask

    task automatic test_word();
        vec_t v[] = '{
            '{"divw_min_1",  1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, LAT_W},
            '{"remuw_f_10",  1'b0, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, LAT_W},
            '{"divuw_f_1",   1'b0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, LAT_W},
            '{"divw_m7_2",   1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, LAT_W},
            '{"remw_m7_2",   1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, '1, LAT_W}
        };
        run_vectors(v);
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, held;
        int          lat;
        logic        bad;
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1, res, lat);
        tests++;
        if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== LAT_W) begin
            fails++;
            $display("[TB] FAIL bp_first_op: got %h lat %0d expected ffffffff80000000 lat %0d", res, lat, LAT_W);
        end
        held = res;
        bad  = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.result !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL bp_hold: got res=%h rdy=%b ov=%b expected res=%h rdy=0 ov=1",
                     bus.result, bus.in_ready, bus.out_valid, held);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_release: got busy=%b rdy=%b ov=%b expected 0 1 0",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, res, lat);
        tests++;
        if (res !== 64'hF || lat !== LAT_W) begin
            fails++;
            $display("[TB] FAIL b2b_op: got %h lat %0d expected f lat %0d", res, lat, LAT_W);
        end
    endtask

    task automatic test_flush();
        logic seen;
        bus.out_ready = 1'b1;
        bus.is_signed = 1'b1;
        bus.is_word   = 1'b0;
        bus.is_rem    = 1'b0;
        bus.num1      = 64'd20;
        bus.num2      = 64'hFFFF_FFFF_FFFF_FFFD;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flush_calc: got busy=%b ov=%b expected 0 0", bus.busy, bus.out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flush_blocks_accept: got busy=%b expected 0", bus.busy);
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy)
                seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("[TB] FAIL flush_no_result: got activity=1 expected 0");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          lat;
        bus.is_signed = 1'b0;
        bus.is_word   = 1'b0;
        bus.is_rem    = 1'b0;
        bus.num1      = 64'd1000;
        bus.num2      = 64'd7;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.result} !== 67'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid: got rdy=%b busy=%b ov=%b res=%h expected all zero",
                     bus.in_ready, bus.busy, bus.out_valid, bus.result);
        end
        rst_n = 1'b1;
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, res, lat);
        tests++;
        if (res !== 64'd2 || lat !== LAT_D) begin
            fails++;
            $display("[TB] FAIL reset_recover: got %h lat %0d expected 2 lat %0d", res, lat, LAT_D);
        end
    endtask

    initial begin
        test_reset();
        test_doubleword();
        test_div_zero();
        test_overflow();
        test_word();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
